// File: rtl/sopc_run_ctrl.sv
// Run/reset controller for the SOPC: sequences core reset, counts run cycles and
// stops the run on a cycle limit or on a fetch PC that stops changing.
module sopc_run_ctrl #(
   parameter int RST_HOLD    = 4,
   parameter int CYCLE_LIMIT = 800,
   parameter int IDLE_LIMIT  = 16,
   parameter int CNT_W       = 23,
   parameter int PC_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PC_W-1:0]  pc_i,
   output logic             core_reset,
   output logic             run_o,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             done,
   output logic [1:0]       done_cause
);

   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int IW = $clog2(IDLE_LIMIT + 1);

   typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_DONE} state_t;

   state_t           state_reg, state_next;
   logic [HW-1:0]    hold_cnt_reg, hold_cnt_next;
   logic [IW-1:0]    idle_cnt_reg, idle_cnt_next;
   logic [PC_W-1:0]  last_pc_reg, last_pc_next;
   logic             pc_vld_reg, pc_vld_next;
   logic             core_reset_reg, core_reset_next;
   logic             run_reg, run_next;
   logic [CNT_W-1:0] cycle_cnt_reg, cycle_cnt_next;
   logic             done_reg, done_next;
   logic [1:0]       done_cause_reg, done_cause_next;
   logic             lim, hlt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_HOLD;
         hold_cnt_reg   <= '0;
         idle_cnt_reg   <= '0;
         last_pc_reg    <= '0;
         pc_vld_reg     <= 1'b0;
         core_reset_reg <= 1'b1;
         run_reg        <= 1'b0;
         cycle_cnt_reg  <= '0;
         done_reg       <= 1'b0;
         done_cause_reg <= 2'b00;
      end else begin
         state_reg      <= state_next;
         hold_cnt_reg   <= hold_cnt_next;
         idle_cnt_reg   <= idle_cnt_next;
         last_pc_reg    <= last_pc_next;
         pc_vld_reg     <= pc_vld_next;
         core_reset_reg <= core_reset_next;
         run_reg        <= run_next;
         cycle_cnt_reg  <= cycle_cnt_next;
         done_reg       <= done_next;
         done_cause_reg <= done_cause_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      hold_cnt_next   = hold_cnt_reg;
      idle_cnt_next   = idle_cnt_reg;
      last_pc_next    = last_pc_reg;
      pc_vld_next     = pc_vld_reg;
      core_reset_next = core_reset_reg;
      run_next        = run_reg;
      cycle_cnt_next  = cycle_cnt_reg;
      done_next       = done_reg;
      done_cause_next = done_cause_reg;
      lim             = 1'b0;
      hlt             = 1'b0;
      case (state_reg)
         ST_HOLD: begin
            if (hold_cnt_reg == HW'(RST_HOLD - 1)) begin
               state_next      = ST_RUN;
               hold_cnt_next   = '0;
               core_reset_next = 1'b0;
               run_next        = 1'b1;
            end else begin
               hold_cnt_next = hold_cnt_reg + HW'(1);
            end
         end
         ST_RUN: begin
            cycle_cnt_next = cycle_cnt_reg + CNT_W'(1);
            last_pc_next   = pc_i;
            pc_vld_next    = 1'b1;
            // last_pc is meaningless until one PC has been captured in RUN
            if (pc_vld_reg && (pc_i == last_pc_reg)) begin
               if (idle_cnt_reg != IW'(IDLE_LIMIT))
                  idle_cnt_next = idle_cnt_reg + IW'(1);
            end else begin
               idle_cnt_next = '0;
            end
            lim = (cycle_cnt_next == CNT_W'(CYCLE_LIMIT));
            hlt = (idle_cnt_next == IW'(IDLE_LIMIT));
            if (lim || hlt) begin
               state_next      = ST_DONE;
               done_next       = 1'b1;
               run_next        = 1'b0;
               done_cause_next = {hlt, lim};
            end
         end
         ST_DONE: begin
            // Frozen until reset; core stays out of reset so its state can be inspected.
         end
         default: state_next = ST_HOLD;
      endcase
   end

   assign core_reset = core_reset_reg;
   assign run_o      = run_reg;
   assign cycle_cnt  = cycle_cnt_reg;
   assign done       = done_reg;
   assign done_cause = done_cause_reg;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Bench for sopc_run_ctrl: two instances (default limits and a short cycle limit)
// share reset and PC, each compared every cycle against an event-level model.
module tb_sopc_run_ctrl;

   localparam int RST_HOLD = 4;
   localparam int IDLE_LIM = 16;
   localparam int CNT_W    = 23;
   localparam int PC_W     = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [PC_W-1:0]  pc;

   logic             a_core_reset, a_run, a_done;
   logic [CNT_W-1:0] a_cnt;
   logic [1:0]       a_cause;
   logic             s_core_reset, s_run, s_done;
   logic [CNT_W-1:0] s_cnt;
   logic [1:0]       s_cause;

   int checks = 0;
   int failures = 0;

   // model state per instance: edges since release, run cycles, repeat streak
   int   cl_tab [2];
   int   m_rel [2];
   int   m_cnt [2];
   int   m_streak [2];
   bit   m_done [2];
   bit   m_have_prev [2];
   int   m_cause [2];
   logic [PC_W-1:0] m_prev [2];

   always #5 clk = ~clk;

   sopc_run_ctrl #(.RST_HOLD(RST_HOLD), .CYCLE_LIMIT(800), .IDLE_LIMIT(IDLE_LIM),
                   .CNT_W(CNT_W), .PC_W(PC_W)) dut_a (
      .clk(clk), .reset(reset), .pc_i(pc),
      .core_reset(a_core_reset), .run_o(a_run), .cycle_cnt(a_cnt),
      .done(a_done), .done_cause(a_cause));

   sopc_run_ctrl #(.RST_HOLD(RST_HOLD), .CYCLE_LIMIT(20), .IDLE_LIMIT(IDLE_LIM),
                   .CNT_W(CNT_W), .PC_W(PC_W)) dut_s (
      .clk(clk), .reset(reset), .pc_i(pc),
      .core_reset(s_core_reset), .run_o(s_run), .cycle_cnt(s_cnt),
      .done(s_done), .done_cause(s_cause));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_rel[k] = 0; m_cnt[k] = 0; m_streak[k] = 0;
            m_done[k] = 0; m_have_prev[k] = 0; m_cause[k] = 0; m_prev[k] = '0;
         end else if (m_done[k]) begin
            // run over: nothing changes
         end else if (m_rel[k] < RST_HOLD) begin
            m_rel[k]++;
         end else begin
            m_cnt[k]++;
            if (m_have_prev[k] && pc == m_prev[k])
               m_streak[k] = (m_streak[k] < IDLE_LIM) ? m_streak[k] + 1 : IDLE_LIM;
            else
               m_streak[k] = 0;
            m_prev[k] = pc;
            m_have_prev[k] = 1;
            if (m_cnt[k] == cl_tab[k] || m_streak[k] == IDLE_LIM) begin
               m_done[k] = 1;
               m_cause[k] = ((m_streak[k] == IDLE_LIM) ? 2 : 0) + ((m_cnt[k] == cl_tab[k]) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_core_reset", k), 32'(k ? s_core_reset : a_core_reset), 32'(m_rel[k] < RST_HOLD));
         chk($sformatf("d%0d_run", k), 32'(k ? s_run : a_run), 32'(m_rel[k] >= RST_HOLD && !m_done[k]));
         chk($sformatf("d%0d_cycle_cnt", k), 32'(k ? s_cnt : a_cnt), 32'(m_cnt[k]));
         chk($sformatf("d%0d_done", k), 32'(k ? s_done : a_done), 32'(m_done[k]));
         chk($sformatf("d%0d_done_cause", k), 32'(k ? s_cause : a_cause), 32'(m_cause[k]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      cl_tab[0] = 800;
      cl_tab[1] = 20;
      reset = 1'b1;
      pc = '0;

      // reset release, hold sequence and cycle-limit stop
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 830; i++) begin
         pc = pc + 32'd4;
         step();
         if (i == 2) chk("t1_core_reset_held", 32'(a_core_reset), 32'd1);
         if (i == 3) chk("t1_core_reset_fall", 32'(a_core_reset), 32'd0);
         if (i == 3) chk("t1_run_rise", 32'(a_run), 32'd1);
         if (i == 4) chk("t1_first_cnt", 32'(a_cnt), 32'd1);
      end
      chk("t2_cnt", 32'(a_cnt), 32'd800);
      chk("t2_cause", 32'(a_cause), 32'd1);
      chk("t2_run", 32'(a_run), 32'd0);

      // PC halt after 50 run cycles
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < RST_HOLD + 49; i++) begin
         pc = pc + 32'd4;
         step();
      end
      pc = 32'h0000_0040;
      repeat (40) step();
      chk("t3_cnt", 32'(a_cnt), 32'd66);
      chk("t3_cause", 32'(a_cause), 32'd2);

      // limit and halt on the same edge
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < RST_HOLD + 3; i++) begin
         pc = pc + 32'd4;
         step();
      end
      pc = 32'h0000_0100;
      repeat (30) step();
      chk("t4_both_cause", 32'(s_cause), 32'd3);
      chk("t4_both_cnt", 32'(s_cnt), 32'd20);

      // idle streak broken once
      reset = 1'b1; step(); reset = 1'b0;
      pc = 32'h0000_0200;
      repeat (RST_HOLD) step();
      for (int i = 1; i <= 40; i++) begin
         pc = (i <= 15) ? 32'h0000_0200 : 32'h0000_0204;
         step();
         if (i == 16) chk("t5_no_early_halt", 32'(a_done), 32'd0);
      end
      chk("t5_cnt", 32'(a_cnt), 32'd32);
      chk("t5_cause", 32'(a_cause), 32'd2);

      // reset mid-run and while done
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < RST_HOLD + 300; i++) begin
         pc = pc + 32'd4;
         step();
      end
      reset = 1'b1; step();
      chk("t6_mid_cnt", 32'(a_cnt), 32'd0);
      chk("t6_mid_core_reset", 32'(a_core_reset), 32'd1);
      reset = 1'b0;
      for (int i = 0; i < RST_HOLD + 810; i++) begin
         pc = pc + 32'd4;
         step();
      end
      chk("t6_done_before", 32'(a_done), 32'd1);
      reset = 1'b1; step();
      chk("t6_done_clear", 32'(a_done), 32'd0);
      chk("t6_cause_clear", 32'(a_cause), 32'd0);
      chk("t6_run_clear", 32'(a_run), 32'd0);
      reset = 1'b0;
      repeat (RST_HOLD) step();
      chk("t6_rerun", 32'(a_run), 32'd1);

      // randomized PC and occasional reset pulses
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 99) < 1);
         if ($urandom_range(0, 99) < 8)
            pc = 32'($urandom_range(0, 3)) << 2;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
